// File: rtl/i2c_slave_rx.sv
// I2C target receiver: synchronizes SCL/SDA, detects START/STOP, ACKs a matching
// write address and each data byte, and buffers received bytes in a FWFT FIFO.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h78,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          scl_in,
    input  logic                          sda_in,
    output logic                          sda_oe,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync_p0;
    logic [SYNC_STAGES-1:0] sda_sync_p0;
    logic                   scl_p1;
    logic                   sda_p1;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [2:0]             bit_cnt;
    logic                   ack_phase;
    logic                   nack;
    logic                   sda_oe_r;
    logic [7:0]             shreg;
    logic [7:0]             byte_in;
    logic                   byte_done;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // Stage p0: synchronizer chains; reset to the idle-high bus level
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
            scl_p1      <= 1'b1;
            sda_p1      <= 1'b1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_in};
            sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_in};
            scl_p1      <= scl_s;
            sda_p1      <= sda_s;
        end
    end

    // Stage p1: edge and bus-condition detection against the previous sample
    always_comb begin
        scl_s     = scl_sync_p0[SYNC_STAGES-1];
        sda_s     = sda_sync_p0[SYNC_STAGES-1];
        scl_rise  = scl_s & ~scl_p1;
        scl_fall  = ~scl_s & scl_p1;
        start_det = scl_s & scl_p1 & sda_p1 & ~sda_s;
        stop_det  = scl_s & scl_p1 & ~sda_p1 & sda_s;
        byte_in   = {shreg[6:0], sda_s};
        byte_done = scl_rise && (bit_cnt == 3'd7);
        fifo_full = (rx_level == LW'(FIFO_DEPTH));
        pop       = rx_valid & rx_ready;
        push      = (state == ST_DATA) && byte_done && (!fifo_full || pop);
    end

    always_ff @(posedge PCLK) begin
        if (scl_rise) begin
            shreg <= byte_in;
        end
    end

    // Stage p2: protocol FSM; sda_oe only ever changes on a detected SCL fall or a bus condition
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            ack_phase  <= 1'b0;
            nack       <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe_r  <= 1'b0;
            end else if (stop_det) begin
                state      <= ST_IDLE;
                ack_phase  <= 1'b0;
                sda_oe_r   <= 1'b0;
                frame_done <= busy;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= 3'd0;
                                ack_phase <= 1'b0;
                                state     <= (byte_in == {SLAVE_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe_r  <= 1'b1;
                                busy      <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe_r  <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                state     <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= 3'd0;
                                ack_phase <= 1'b0;
                                state     <= ST_DATA_ACK;
                                nack      <= !push;
                                if (!push) begin
                                    overflow <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe_r  <= !nack;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe_r  <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                state     <= nack ? ST_IGNORE : ST_DATA;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Reset releases the bus combinationally so SDA is never held through reset
    assign sda_oe = sda_oe_r & ~PRESET;

    // Stage p2: receive FIFO; storage is not reset, only pointers and level
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   rx_level <= rx_level + LW'(1);
                2'b01:   rx_level <= rx_level - LW'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

    assign rx_valid = (rx_level != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged I2C master on an open-drain SDA
// line, a byte-level vector table, and hand sequences for pops, repeated START and abort.
module tb_i2c_slave_rx;

    localparam int Q = 4;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_level;
    logic       busy;
    logic       frame_done;
    logic       overflow;
    logic       sda_bus;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_cnt = 0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_rx #(.SLAVE_ADDR(7'h78), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .scl_in(scl_m),
        .sda_in(sda_bus),
        .sda_oe(sda_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_level(rx_level),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (frame_done) frame_cnt <= frame_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit         st;
        logic [7:0] tx;
        bit         sp;
        bit         ack;
        bit         bsy;
        int         lvl;
        bit         ovf;
        int         frames;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic do_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic oe_last);
        oe_last = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; cyc(Q);
            scl_m = 1'b1; cyc(Q);
            oe_last = sda_oe;
            cyc(Q);
            scl_m = 1'b0; cyc(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe8,
                             output logic oe9, output logic oe_after);
        send_bits(b, 8, oe8);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        ack = ~sda_bus;
        oe9 = sda_oe;
        cyc(Q);
        scl_m = 1'b0; cyc(Q);
        oe_after = sda_oe;
    endtask

    logic ack, oe8, oe9, oea;

    initial begin
        tbl[0]  = '{1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1};
        tbl[1]  = '{1'b1, 8'hF2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1};
        tbl[2]  = '{1'b1, 8'hF1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1};
        tbl[3]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1};
        for (int i = 0; i < 8; i++) begin
            tbl[4 + i] = '{1'b0, 8'(i + 1), 1'b0, 1'b1, 1'b1, i + 1, 1'b0, 1};
        end
        tbl[12] = '{1'b0, 8'h09, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1};
        tbl[13] = '{1'b0, 8'h0A, 1'b1, 1'b0, 1'b1, 8, 1'b1, 2};

        // Reset with the bus idle
        PRESET = 1'b1;
        cyc(5);
        check("rst sda_oe", sda_oe, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_level", rx_level, 0);
        check("rst rx_data", rx_data, 0);
        check("rst busy", busy, 0);
        check("rst overflow", overflow, 0);
        check("rst frame_done", frame_done, 0);
        PRESET = 1'b0;
        cyc(4);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].st) do_start();
            send_byte(tbl[i].tx, ack, oe8, oe9, oea);
            check($sformatf("v%0d ack", i), ack, tbl[i].ack);
            check($sformatf("v%0d oe_bit9", i), oe9, tbl[i].ack);
            check($sformatf("v%0d oe_bit8", i), oe8, 0);
            check($sformatf("v%0d oe_after", i), oea, 0);
            check($sformatf("v%0d busy", i), busy, tbl[i].bsy);
            check($sformatf("v%0d level", i), rx_level, tbl[i].lvl);
            check($sformatf("v%0d overflow", i), overflow, tbl[i].ovf);
            if (tbl[i].sp) begin
                do_stop();
                cyc(2);
                check($sformatf("v%0d busy_after_stop", i), busy, 0);
                check($sformatf("v%0d frames", i), frame_cnt, tbl[i].frames);
            end
        end

        // Drain the full FIFO in order
        check("pop pre valid", rx_valid, 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pop%0d data", i), rx_data, i + 1);
            cyc(1);
        end
        rx_ready = 1'b0;
        check("pop end valid", rx_valid, 0);
        check("pop end level", rx_level, 0);
        check("pop end data", rx_data, 0);
        check("ovf sticky", overflow, 1);
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        check("ovf cleared", overflow, 0);

        // Repeated START between two writes
        do_start();
        send_byte(8'hF0, ack, oe8, oe9, oea);
        check("rs addr1 ack", ack, 1);
        send_byte(8'hAA, ack, oe8, oe9, oea);
        check("rs AA ack", ack, 1);
        do_start();
        send_byte(8'hF0, ack, oe8, oe9, oea);
        check("rs addr2 ack", ack, 1);
        send_byte(8'h55, ack, oe8, oe9, oea);
        check("rs 55 ack", ack, 1);
        do_stop();
        cyc(2);
        check("rs level", rx_level, 2);
        check("rs head AA", rx_data, 8'hAA);
        check("rs frames", frame_cnt, 3);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        check("rs head 55", rx_data, 8'h55);

        // Abort by reset while the address ACK is being driven
        do_start();
        send_byte(8'hF0, ack, oe8, oe9, oea);
        send_byte(8'h33, ack, oe8, oe9, oea);
        check("abort pre level", rx_level, 2);
        do_start();
        send_bits(8'hF0, 8, oe8);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        check("abort pre oe", sda_oe, 1);
        PRESET = 1'b1;
        cyc(1);
        check("abort oe", sda_oe, 0);
        check("abort valid", rx_valid, 0);
        check("abort level", rx_level, 0);
        check("abort busy", busy, 0);
        cyc(3);
        PRESET = 1'b0;
        cyc(4);

        // START in the middle of a data byte discards the partial byte
        do_start();
        send_byte(8'hF0, ack, oe8, oe9, oea);
        check("glitch addr ack", ack, 1);
        send_bits(8'hA0, 4, oe8);
        do_start();
        send_byte(8'hF0, ack, oe8, oe9, oea);
        send_byte(8'h5A, ack, oe8, oe9, oea);
        check("glitch 5A ack", ack, 1);
        do_stop();
        cyc(2);
        check("glitch level", rx_level, 1);
        check("glitch data", rx_data, 8'h5A);
        check("glitch busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
